// File: rtl/cmp_arb_if.sv
// Two-requester compare bus: operand/op handshakes in, a single
// response slot out.
interface cmp_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_result;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/cmp_arb.sv
// Arbitrates two compare requesters onto one shared 32-bit comparator
// feeding a one-entry response slot (round-robin or fixed priority).
module cmp_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  cmp_arb_if.slave  bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_id;
  logic        r_res;

  logic        w_free;
  logic        w_v0;
  logic        w_v1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_take;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [1:0]  w_op;
  logic        w_res;

  assign w_v0 = bus.req0_valid;
  assign w_v1 = bus.req1_valid;

  // rst_n gating keeps readys low while reset forces the slot EMPTY
  assign w_free = rst_n
                & ((r_state == S_EMPTY) | bus.rsp_ready);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_free) begin
      unique case (1'b1)
        (w_v0 & ~w_v1): w_gnt0 = 1'b1;
        (~w_v0 & w_v1): w_gnt1 = 1'b1;
        (w_v0 & w_v1): begin
          if (FIXED_PRIO || r_last)
            w_gnt0 = 1'b1;
          else
            w_gnt1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_take = w_gnt0 | w_gnt1;

  assign w_a  = w_gnt1 ? bus.req1_a  : bus.req0_a;
  assign w_b  = w_gnt1 ? bus.req1_b  : bus.req0_b;
  assign w_op = w_gnt1 ? bus.req1_op : bus.req0_op;

  always_comb begin
    w_res = 1'b0;
    unique case (w_op)
      2'b00: w_res = (w_a == w_b);
      2'b01: w_res = (w_a != w_b);
      2'b10: w_res = ($signed(w_a) < $signed(w_b));
      2'b11: w_res = (w_a < w_b);
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_take) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (bus.rsp_ready && !w_take)
          w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_res   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_last <= w_gnt1;
        r_id   <= w_gnt1;
        r_res  <= w_res;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp_valid  = (r_state == S_FULL);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_res;

endmodule

// File: tb/tb_cmp_arb.sv
// Directed bench: one round-robin and one fixed-priority instance
// driven with identical stimulus.
module tb_cmp_arb;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cmp_arb_if bus_rr ();
  cmp_arb_if bus_fp ();

  cmp_arb #(.FIXED_PRIO(1'b0)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  cmp_arb #(.FIXED_PRIO(1'b1)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] op);
    bus_rr.req0_valid = v;  bus_fp.req0_valid = v;
    bus_rr.req0_a = a;      bus_fp.req0_a = a;
    bus_rr.req0_b = b;      bus_fp.req0_b = b;
    bus_rr.req0_op = op;    bus_fp.req0_op = op;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] op);
    bus_rr.req1_valid = v;  bus_fp.req1_valid = v;
    bus_rr.req1_a = a;      bus_fp.req1_a = a;
    bus_rr.req1_b = b;      bus_fp.req1_b = b;
    bus_rr.req1_op = op;    bus_fp.req1_op = op;
  endtask

  task automatic set_rdy(input logic r);
    bus_rr.rsp_ready = r;
    bus_fp.rsp_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic [1:0]  op_c [4];
  logic        op_r [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    op_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    op_b = '{32'h1, 32'h1, 32'h1, 32'h1};
    op_c = '{2'b10, 2'b11, 2'b01, 2'b00};
    op_r = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    drv0(1'b1, 32'h5, 32'h5, 2'b00);
    drv1(1'b0, 32'h0, 32'h0, 2'b00);
    set_rdy(1'b1);
    #13;
    chk("rst_valid", bus_rr.rsp_valid, 0);
    chk("rst_id", bus_rr.rsp_id, 0);
    chk("rst_res", bus_rr.rsp_result, 0);
    chk("rst_rdy0", bus_rr.req0_ready, 0);
    chk("rst_rdy0_fp", bus_fp.req0_ready, 0);

    // single requester, EQ
    rst_n = 1'b1;
    #1;
    chk("c0_rdy0", bus_rr.req0_ready, 1);
    chk("c0_rdy1", bus_rr.req1_ready, 0);
    step();
    chk("c1_valid", bus_rr.rsp_valid, 1);
    chk("c1_id", bus_rr.rsp_id, 0);
    chk("c1_res", bus_rr.rsp_result, 1);

    // signed/unsigned boundary table
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, op_a[i], op_b[i], op_c[i]);
      #1;
      chk("bnd_rdy0", bus_rr.req0_ready, 1);
      step();
      chk("bnd_res", bus_rr.rsp_result, op_r[i]);
      chk("bnd_valid", bus_rr.rsp_valid, 1);
    end

    // tie arbitration from a fresh reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    drv0(1'b1, 32'h5, 32'h5, 2'b01);
    drv1(1'b1, 32'h3, 32'h7, 2'b10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy0", bus_rr.req0_ready, (i % 2) == 0);
      chk("rr_rdy1", bus_rr.req1_ready, (i % 2) == 1);
      chk("fp_rdy0", bus_fp.req0_ready, 1);
      chk("fp_rdy1", bus_fp.req1_ready, 0);
      step();
      chk("rr_id", bus_rr.rsp_id, i % 2);
      chk("rr_res", bus_rr.rsp_result, i % 2);
      chk("fp_id", bus_fp.rsp_id, 0);
      chk("fp_valid", bus_fp.rsp_valid, 1);
    end

    // backpressure: slot must hold, no grants
    set_rdy(1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy0", bus_rr.req0_ready, 0);
      chk("bp_rdy1", bus_rr.req1_ready, 0);
      chk("bp_rdy0_fp", bus_fp.req0_ready, 0);
      step();
      chk("bp_valid", bus_rr.rsp_valid, 1);
      chk("bp_id", bus_rr.rsp_id, 1);
      chk("bp_res", bus_rr.rsp_result, 1);
    end
    set_rdy(1'b1);
    #1;
    chk("drain_rdy0", bus_rr.req0_ready, 1);
    chk("drain_rdy1", bus_rr.req1_ready, 0);
    step();
    chk("nogap_valid", bus_rr.rsp_valid, 1);
    chk("nogap_id", bus_rr.rsp_id, 0);
    chk("nogap_res", bus_rr.rsp_result, 0);

    // drain with nothing pending empties the slot
    drv0(1'b0, 32'h0, 32'h0, 2'b00);
    drv1(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    chk("empty_valid", bus_rr.rsp_valid, 0);
    chk("empty_id", bus_rr.rsp_id, 0);

    // EMPTY accepts even without rsp_ready
    set_rdy(1'b0);
    drv1(1'b1, 32'h8, 32'h2, 2'b11);
    #1;
    chk("emp_rdy1", bus_rr.req1_ready, 1);
    step();
    drv1(1'b0, 32'h0, 32'h0, 2'b00);
    chk("emp_valid", bus_rr.rsp_valid, 1);
    chk("emp_id", bus_rr.rsp_id, 1);
    chk("emp_res", bus_rr.rsp_result, 0);

    // async reset while FULL
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus_rr.rsp_valid, 0);
    chk("arst_id", bus_rr.rsp_id, 0);
    #2;
    rst_n = 1'b1;
    set_rdy(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_valid", bus_rr.rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_arb.md
CMP_ARB -- requirements
Module: cmp_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 selects round-robin arbitration; 1 gives requester 0 strict priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 (branch unit) has a compare pending.
REQ-005 req0_ready  output  1  requester 0 compare is accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 compare op.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths/directions as requester 0, for requester 1 (trap/conditional unit).
REQ-009 rsp_valid  output  1  response slot holds a result.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 rsp_id  output  1  index of the requester owning the response.
REQ-012 rsp_result  output  1  compare outcome.

Function
REQ-013 Op encoding SHALL be: 00 EQ (a==b); 01 NE (a!=b); 10 LT signed (a<b, 2's complement); 11 LTU (a<b, unsigned).
REQ-014 Exactly one shared 32-bit comparator SHALL evaluate the granted requester's operands.
REQ-015 Output slot FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 slot_free SHALL be: state EMPTY, or state FULL with rsp_ready=1.
REQ-017 A grant SHALL occur only when slot_free=1 and at least one reqN_valid=1.
REQ-018 At most one of req0_ready/req1_ready SHALL be 1 in any cycle; reqN_ready=1 only when reqN_valid=1 and N is granted.
REQ-019 Handshake on requester N SHALL be reqN_valid & reqN_ready; the requester SHALL keep its operands stable until accepted.
REQ-020 With only one requester valid, it SHALL be granted (when slot_free).
REQ-021 FIXED_PRIO=0, both valid: the requester other than last_grant SHALL win; last_grant SHALL update to the winner on every grant.
REQ-022 FIXED_PRIO=1, both valid: requester 0 SHALL win.
REQ-023 On grant, next edge SHALL load rsp_result from the comparator and rsp_id from the winner, and SHALL set state FULL (latency 1 cycle).
REQ-024 FULL with rsp_ready=0: rsp_valid, rsp_id and rsp_result SHALL hold stable, and no grant SHALL occur.
REQ-025 FULL with rsp_ready=1 and no grant: state SHALL become EMPTY.
REQ-026 FULL with rsp_ready=1 and a grant in the same cycle: the slot SHALL reload with no bubble (throughput 1 compare/cycle).
REQ-027 rsp_result and rsp_id SHALL not change while state EMPTY.

Reset
REQ-028 rst_n=0 SHALL immediately force rsp_valid=0, rsp_id=0, rsp_result=0, state EMPTY, last_grant=1.
REQ-029 req0_ready and req1_ready SHALL be 0 while rst_n=0.
REQ-030 Reset mid-operation SHALL discard any held response; no response SHALL appear after reset deasserts without a new handshake.
REQ-031 First tie after reset SHALL go to requester 0 (last_grant=1).

Verification
REQ-032 Reset release, req0 valid only, a=b=0x0000_0005, op=00, rsp_ready=1 -> req0_ready=1 in cycle 0; rsp_valid=1, rsp_id=0, rsp_result=1 in cycle 1.
REQ-033 Signed/unsigned boundary: a=0xFFFF_FFFF, b=0x0000_0001 -> op=10 yields result 1; op=11 yields result 0; op=01 yields result 1.
REQ-034 Both requesters valid for 4 cycles, FIXED_PRIO=0, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
REQ-035 Same stimulus with FIXED_PRIO=1 -> all four grants go to requester 0; req1_ready stays 0.
REQ-036 Backpressure: response FULL with rsp_ready=0 for 3 cycles, both valid -> no readys and stable response; rsp_ready=1 -> drain and new grant in the same cycle, new rsp_valid the next cycle with no gap.
REQ-037 Assert rst_n=0 asynchronously while FULL -> rsp_valid drops before the next clock edge; after release with no requests, rsp_valid stays 0.
